// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the registered RV32I decode/control stage:
//   - RV32I major opcode constants
//   - packed control word layout (CTRL_W = 16 bits)
//   - immediate-format and result-source encodings
//   - decode-stage FSM state type
//   - helper for recognising CSR-access funct3 values
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int CTRL_W = 16;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Immediate formats (ImmSrc field)
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Result sources (ResultSrc field)
    localparam logic [2:0] RES_ALU = 3'b000;
    localparam logic [2:0] RES_MEM = 3'b001;
    localparam logic [2:0] RES_PC4 = 3'b010;
    localparam logic [2:0] RES_IMM = 3'b011;
    localparam logic [2:0] RES_CSR = 3'b100;

    // ALU operation classes (ALUOp field)
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // SYSTEM sub-decode constants
    localparam logic [2:0]  F3_PRIV     = 3'b000;
    localparam logic [11:0] F12_ECALL   = 12'h000;
    localparam logic [11:0] F12_EBREAK  = 12'h001;

    // Control word, MSB first so that bit 0 is reg_write.
    typedef struct packed {
        logic       ebreak;      // [15]
        logic       ecall;       // [14]
        logic [1:0] alu_op;      // [13:12]
        logic [2:0] result_src;  // [11:9]
        logic [2:0] imm_src;     // [8:6]
        logic       alu_a_pc;    // [5]
        logic       jump;        // [4]
        logic       branch;      // [3]
        logic       alu_src;     // [2]
        logic       mem_write;   // [1]
        logic       reg_write;   // [0]
    } ctrl_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    // CSR access funct3 values: everything except the privileged group (000)
    // and the reserved encoding (100).
    function automatic logic is_csr_funct3(input logic [2:0] f3);
        return (f3 != 3'b000) && (f3 != 3'b100);
    endfunction

endpackage

// File: rtl/decode_ctrl_comb.sv
// -----------------------------------------------------------------------------
// decode_ctrl_comb
// Pure combinational RV32I main decoder: raw instruction -> packed control word
// plus an illegal flag. An illegal instruction yields an all-zero (bubble)
// control word.
//
// Configuration macro: DECODE_CSR_EN
//   defined   : SYSTEM with funct3 in {001,010,011,101,110,111} decodes as a
//               CSR access (RegWrite, ImmSrc=I, ResultSrc=CSR); funct3=100 illegal
//   undefined : every SYSTEM with funct3 != 000 is illegal
//
// Ports
//   i_instr    in   32      raw instruction word
//   o_ctrl     out  CTRL_W  packed control word (bubble when illegal)
//   o_illegal  out  1       instruction is not a supported RV32I encoding
// -----------------------------------------------------------------------------
module decode_ctrl_comb
    import decode_pkg::*;
(
    input  logic [31:0]       i_instr,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic              o_illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [11:0] w_funct12;
    ctrl_t       w_ctrl;
    logic        w_illegal;
    // Register-specifier fields do not affect control decode.
    logic        w_unused_fields;

    assign w_opcode        = i_instr[6:0];
    assign w_funct3        = i_instr[14:12];
    assign w_funct12       = i_instr[31:20];
    assign w_unused_fields = ^{i_instr[19:15], i_instr[11:7]};

    // Opcode decode into control fields; anything unrecognised is illegal
    always_comb begin
        w_ctrl    = ctrl_t'({CTRL_W{1'b0}});
        w_illegal = 1'b0;
        case (w_opcode)
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.result_src = RES_MEM;
                w_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_S;
                w_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_BRANCH: begin
                w_ctrl.branch     = 1'b1;
                w_ctrl.imm_src    = IMM_B;
                w_ctrl.alu_op     = ALUOP_BR;
            end
            OP_OP: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = RES_ALU;
                w_ctrl.alu_op     = ALUOP_R;
            end
            OP_OPIMM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.alu_op     = ALUOP_I;
            end
            OP_JAL: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_ctrl.imm_src    = IMM_J;
                w_ctrl.result_src = RES_PC4;
            end
            OP_JALR: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.jump       = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_I;
                w_ctrl.result_src = RES_PC4;
            end
            OP_LUI: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.imm_src    = IMM_U;
                w_ctrl.result_src = RES_IMM;
            end
            OP_AUIPC: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_a_pc   = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.imm_src    = IMM_U;
                w_ctrl.alu_op     = ALUOP_ADD;
                w_ctrl.result_src = RES_ALU;
            end
            OP_SYSTEM: begin
                if (w_funct3 == F3_PRIV) begin
                    if (w_funct12 == F12_ECALL) begin
                        w_ctrl.ecall = 1'b1;
                    end else if (w_funct12 == F12_EBREAK) begin
                        w_ctrl.ebreak = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
`ifdef DECODE_CSR_EN
                    if (is_csr_funct3(w_funct3)) begin
                        w_ctrl.reg_write  = 1'b1;
                        w_ctrl.imm_src    = IMM_I;
                        w_ctrl.result_src = RES_CSR;
                    end else begin
                        w_illegal = 1'b1;
                    end
`else
                    w_illegal = 1'b1;
`endif
                end
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Illegal instructions must leave the pipeline as a bubble.
    assign o_ctrl    = w_illegal ? {CTRL_W{1'b0}} : w_ctrl;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
// Registered, valid/ready handshaked RV32I decode stage between IF/ID and ID/EX.
// Holds up to two decoded instructions (output register + one skid entry),
// raises an illegal-instruction trap handshake and counts accepted illegal
// instructions with a saturating counter.
//
// Configuration macro: DECODE_CSR_EN (passed through to decode_ctrl_comb;
//   enables decode of CSR-access SYSTEM instructions)
//
// Parameters
//   TAG_W  width of the sideband tag (normally the PC)
//   CNT_W  width of the saturating illegal-instruction counter
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous reset, active-high
//   in_valid     in   1       instr/in_tag valid
//   in_ready     out  1       stage can accept (registered)
//   instr        in   32      raw instruction word
//   in_tag       in   TAG_W   sideband tag
//   flush        in   1       discard all held instructions, return to RUN
//   out_valid    out  1       out_ctrl/out_tag/out_illegal valid
//   out_ready    in   1       downstream accepts
//   out_ctrl     out  CTRL_W  packed control word
//   out_tag      out  TAG_W   tag of emitted instruction
//   out_illegal  out  1       emitted instruction is illegal (ctrl is a bubble)
//   trap_req     out  1       illegal-instruction trap pending
//   trap_ack     in   1       trap controller has taken the trap
//   illegal_cnt  out  CNT_W   accepted illegal instructions, saturating
// -----------------------------------------------------------------------------
module decode_ctrl_stage
    import decode_pkg::*;
#(
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic              trap_req,
    input  logic              trap_ack,
    output logic [CNT_W-1:0]  illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // Decoder outputs for the instruction currently on the input
    logic [CTRL_W-1:0] w_dec_ctrl;
    logic              w_dec_illegal;

    // Registered state
    state_e            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_illegal;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [TAG_W-1:0]  r_skid_tag;
    logic              r_skid_illegal;
    logic [CNT_W-1:0]  r_illegal_cnt;

    // Next-state values
    state_e            w_state_nxt;
    logic              w_in_ready_nxt;
    logic              w_out_valid_nxt;
    logic [CTRL_W-1:0] w_out_ctrl_nxt;
    logic [TAG_W-1:0]  w_out_tag_nxt;
    logic              w_out_illegal_nxt;
    logic              w_skid_valid_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [TAG_W-1:0]  w_skid_tag_nxt;
    logic              w_skid_illegal_nxt;
    logic [CNT_W-1:0]  w_illegal_cnt_nxt;

    // Handshake events this cycle
    logic              w_accept;
    logic              w_pop;
    logic              w_accept_illegal;

    decode_ctrl_comb u_decode (
        .i_instr   (instr),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal)
    );

    // A flush cycle never accepts, even if in_ready is high.
    assign w_accept         = in_valid & r_in_ready & ~flush;
    assign w_pop            = r_out_valid & out_ready;
    assign w_accept_illegal = w_accept & w_dec_illegal;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: trap on an accepted illegal, leave on trap_ack or flush
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept_illegal) begin
                        w_state_nxt = ST_TRAP;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_TRAP: begin
                    if (trap_ack) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_TRAP;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    // Output register / skid entry movement and illegal counter next values
    always_comb begin
        w_out_valid_nxt    = r_out_valid;
        w_out_ctrl_nxt     = r_out_ctrl;
        w_out_tag_nxt      = r_out_tag;
        w_out_illegal_nxt  = r_out_illegal;
        w_skid_valid_nxt   = r_skid_valid;
        w_skid_ctrl_nxt    = r_skid_ctrl;
        w_skid_tag_nxt     = r_skid_tag;
        w_skid_illegal_nxt = r_skid_illegal;
        w_illegal_cnt_nxt  = r_illegal_cnt;

        if (flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else begin
            if (!r_out_valid || w_pop) begin
                // Output register is free next cycle: the skid entry is older
                // than anything arriving now, so it goes first. in_ready was
                // low while the skid was full, so no accept can collide here.
                if (r_skid_valid) begin
                    w_out_valid_nxt   = 1'b1;
                    w_out_ctrl_nxt    = r_skid_ctrl;
                    w_out_tag_nxt     = r_skid_tag;
                    w_out_illegal_nxt = r_skid_illegal;
                    w_skid_valid_nxt  = 1'b0;
                end else if (w_accept) begin
                    w_out_valid_nxt   = 1'b1;
                    w_out_ctrl_nxt    = w_dec_ctrl;
                    w_out_tag_nxt     = in_tag;
                    w_out_illegal_nxt = w_dec_illegal;
                end else begin
                    w_out_valid_nxt   = 1'b0;
                end
            end else begin
                // Output stalled: a newly accepted instruction parks in the skid.
                if (w_accept) begin
                    w_skid_valid_nxt   = 1'b1;
                    w_skid_ctrl_nxt    = w_dec_ctrl;
                    w_skid_tag_nxt     = in_tag;
                    w_skid_illegal_nxt = w_dec_illegal;
                end else begin
                    w_skid_valid_nxt   = r_skid_valid;
                end
            end

            if (w_accept_illegal && (r_illegal_cnt != CNT_MAX)) begin
                w_illegal_cnt_nxt = r_illegal_cnt + CNT_ONE;
            end else begin
                w_illegal_cnt_nxt = r_illegal_cnt;
            end
        end

        // in_ready is registered from the next-cycle occupancy and state.
        w_in_ready_nxt = ~w_skid_valid_nxt & (w_state_nxt == ST_RUN);
    end

    // Datapath, handshake and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_ctrl     <= {CTRL_W{1'b0}};
            r_out_tag      <= {TAG_W{1'b0}};
            r_out_illegal  <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_skid_ctrl    <= {CTRL_W{1'b0}};
            r_skid_tag     <= {TAG_W{1'b0}};
            r_skid_illegal <= 1'b0;
            r_illegal_cnt  <= {CNT_W{1'b0}};
        end else begin
            r_in_ready     <= w_in_ready_nxt;
            r_out_valid    <= w_out_valid_nxt;
            r_out_ctrl     <= w_out_ctrl_nxt;
            r_out_tag      <= w_out_tag_nxt;
            r_out_illegal  <= w_out_illegal_nxt;
            r_skid_valid   <= w_skid_valid_nxt;
            r_skid_ctrl    <= w_skid_ctrl_nxt;
            r_skid_tag     <= w_skid_tag_nxt;
            r_skid_illegal <= w_skid_illegal_nxt;
            r_illegal_cnt  <= w_illegal_cnt_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_ctrl    = r_out_ctrl;
    assign out_tag     = r_out_tag;
    assign out_illegal = r_out_illegal;
    assign trap_req    = (r_state == ST_TRAP);
    assign illegal_cnt = r_illegal_cnt;

endmodule
